// File: rtl/follower_lanes_pkg.sv
// Shared screen geometry, LFSR constants and lane state for the obstacle-lane block.
// Scroll step and screen size must agree with the vertical-scroll controller.
package follower_lanes_pkg;

    localparam int          SCREEN_W  = 640;
    localparam int          SCREEN_H  = 480;
    localparam int          MOVE_AMT  = 2;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] x;
        logic       dir;
        logic [1:0] speed;
    } lane_t;

    // Galois LFSR, right-shifting; taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // (p - start) mod size for start < size; callers compare the result against an extent.
    function automatic logic [11:0] wrap_off(input logic [9:0] p, input logic [9:0] start,
                                             input logic [11:0] size);
        logic [11:0] d;
        d = {2'b00, p} - {2'b00, start};
        if (d[11])
            d = d + size;
        if (d >= size)
            d = d - size;
        return d;
    endfunction

endpackage

// File: rtl/follower_lanes_lane.sv
// One obstacle lane: vertical scroll with respawn, horizontal car motion,
// and the pixel / player footprint tests for this lane's car.
module follower_lane #(
    parameter int LANE_IDX   = 0,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int MOVE_AMT   = 2,
    parameter int LANE_PITCH = 120,
    parameter int CAR_W      = 32,
    parameter int CAR_H      = 24,
    parameter int PLAYER_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_followers,
    input  logic       frame_tick,
    input  logic [9:0] rnd_x,
    input  logic       rnd_dir,
    input  logic [1:0] rnd_speed,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       pix_hit,
    output logic       player_hit
);
    import follower_lanes_pkg::*;

    localparam logic [11:0] W12     = 12'(SCREEN_W);
    localparam logic [11:0] H12     = 12'(SCREEN_H);
    localparam logic [9:0]  Y_RST   = 10'((LANE_IDX * LANE_PITCH) % SCREEN_H);
    localparam logic [9:0]  X_RST   = 10'((LANE_IDX * 160) % SCREEN_W);
    localparam logic        DIR_RST = (LANE_IDX % 2) != 0;

    lane_t       lane_reg;
    lane_t       lane_next;
    logic [10:0] y_sum;
    logic [10:0] x_fwd;
    logic [10:0] resp_x;
    logic        wrap;

    always_comb begin
        lane_next = lane_reg;
        y_sum     = {1'b0, lane_reg.y} + 11'(MOVE_AMT);
        wrap      = y_sum >= 11'(SCREEN_H);
        resp_x    = {1'b0, rnd_x ^ 10'(LANE_IDX)};
        if (resp_x >= 11'(SCREEN_W))
            resp_x = resp_x - 11'(SCREEN_W);
        x_fwd     = {1'b0, lane_reg.x} + {9'b0, lane_reg.speed};

        // A lane that wraps this cycle takes fresh respawn values and skips its horizontal step.
        if (move_followers && wrap) begin
            lane_next.y     = 10'(y_sum - 11'(SCREEN_H));
            lane_next.x     = resp_x[9:0];
            lane_next.dir   = rnd_dir;
            lane_next.speed = (rnd_speed == 2'd0) ? 2'd1 : rnd_speed;
        end else begin
            if (move_followers)
                lane_next.y = y_sum[9:0];
            if (frame_tick) begin
                if (lane_reg.dir)
                    lane_next.x = (x_fwd >= 11'(SCREEN_W)) ? 10'(x_fwd - 11'(SCREEN_W)) : x_fwd[9:0];
                else if (lane_reg.x < {8'b0, lane_reg.speed})
                    lane_next.x = 10'({1'b0, lane_reg.x} + 11'(SCREEN_W) - {9'b0, lane_reg.speed});
                else
                    lane_next.x = lane_reg.x - {8'b0, lane_reg.speed};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            lane_reg <= '{y: Y_RST, x: X_RST, dir: DIR_RST, speed: 2'd1};
        else
            lane_reg <= lane_next;
    end

    // Circular intervals overlap iff either start lies inside the other interval.
    assign pix_hit = (wrap_off(pix_x, lane_reg.x, W12) < 12'(CAR_W)) &&
                     (wrap_off(pix_y, lane_reg.y, H12) < 12'(CAR_H));

    assign player_hit = ((wrap_off(player_x, lane_reg.x, W12) < 12'(CAR_W)) ||
                         (wrap_off(lane_reg.x, player_x, W12) < 12'(PLAYER_W))) &&
                        ((wrap_off(player_y, lane_reg.y, H12) < 12'(CAR_H)) ||
                         (wrap_off(lane_reg.y, player_y, H12) < 12'(PLAYER_W)));

endmodule

// File: rtl/follower_lanes.sv
// Obstacle lanes that scroll with the background: shared LFSR, per-pixel
// obstacle query for the renderer and a sticky player-collision flag.
module follower_lanes #(
    parameter int          NUM_LANES  = 4,
    parameter int          MOVE_AMT   = follower_lanes_pkg::MOVE_AMT,
    parameter int          SCREEN_H   = follower_lanes_pkg::SCREEN_H,
    parameter int          SCREEN_W   = follower_lanes_pkg::SCREEN_W,
    parameter int          LANE_PITCH = 120,
    parameter int          CAR_W      = 32,
    parameter int          CAR_H      = 24,
    parameter int          PLAYER_W   = 16,
    parameter logic [15:0] LFSR_SEED  = follower_lanes_pkg::LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_followers,
    input  logic       frame_tick,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       clear_hit,
    output logic       obstacle_px,
    output logic       collision
);
    import follower_lanes_pkg::*;

    logic [15:0]          lfsr_reg;
    logic                 obstacle_px_reg;
    logic                 collision_reg;
    logic [NUM_LANES-1:0] pix_hit;
    logic [NUM_LANES-1:0] player_hit;
    logic                 pix_on_screen;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        follower_lane #(
            .LANE_IDX   (gi),
            .SCREEN_W   (SCREEN_W),
            .SCREEN_H   (SCREEN_H),
            .MOVE_AMT   (MOVE_AMT),
            .LANE_PITCH (LANE_PITCH),
            .CAR_W      (CAR_W),
            .CAR_H      (CAR_H),
            .PLAYER_W   (PLAYER_W)
        ) u_lane (
            .clk            (clk),
            .reset          (reset),
            .move_followers (move_followers),
            .frame_tick     (frame_tick),
            .rnd_x          (lfsr_reg[15:6]),
            .rnd_dir        (lfsr_reg[0]),
            .rnd_speed      (lfsr_reg[2:1]),
            .pix_x          (pix_x),
            .pix_y          (pix_y),
            .player_x       (player_x),
            .player_y       (player_y),
            .pix_hit        (pix_hit[gi]),
            .player_hit     (player_hit[gi])
        );
    end

    assign pix_on_screen = (pix_x < 10'(SCREEN_W)) && (pix_y < 10'(SCREEN_H));

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg        <= LFSR_SEED;
            obstacle_px_reg <= 1'b0;
            collision_reg   <= 1'b0;
        end else begin
            lfsr_reg        <= lfsr_step(lfsr_reg);
            obstacle_px_reg <= pix_on_screen && (|pix_hit);
            // A fresh overlap wins over clear_hit in the same cycle.
            collision_reg   <= (|player_hit) || (collision_reg && !clear_hit);
        end
    end

    assign obstacle_px = obstacle_px_reg;
    assign collision   = collision_reg;

endmodule

// File: tb/tb_follower_lanes.sv
// Randomised bench for follower_lanes with a behavioural lane model and
// directed probes of reset, wrap, respawn and collision behaviour.
module tb_follower_lanes;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_followers;
    logic       frame_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       clear_hit;
    logic       obstacle_px;
    logic       collision;

    follower_lanes dut (
        .clk            (clk),
        .reset          (reset),
        .move_followers (move_followers),
        .frame_tick     (frame_tick),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .player_x       (player_x),
        .player_y       (player_y),
        .clear_hit      (clear_hit),
        .obstacle_px    (obstacle_px),
        .collision      (collision)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 0;

    // Behavioural model state
    int m_y[4];
    int m_x[4];
    int m_dir[4];
    int m_spd[4];
    int m_lfsr;
    bit exp_obs;
    bit exp_col;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_span(input int p, input int start, input int ext, input int size);
        return ((((p - start) % size) + size) % size) < ext;
    endfunction

    function automatic bit covers(input int i, input int px, input int py);
        return in_span(px, m_x[i], 32, 640) && in_span(py, m_y[i], 24, 480);
    endfunction

    // Next state of the lanes and outputs, using the inputs held across the last edge.
    task automatic model_update();
        bit hit;
        bit hx;
        bit hy;
        bit resp;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_y[i]   = i * 120;
                m_x[i]   = (i * 160) % 640;
                m_dir[i] = i % 2;
                m_spd[i] = 1;
            end
            m_lfsr  = 'hACE1;
            exp_obs = 0;
            exp_col = 0;
        end else begin
            exp_obs = 0;
            if (pix_x < 640 && pix_y < 480)
                for (int i = 0; i < 4; i++)
                    if (covers(i, int'(pix_x), int'(pix_y))) exp_obs = 1;
            hit = 0;
            for (int i = 0; i < 4; i++) begin
                hx = 0;
                hy = 0;
                for (int d = 0; d < 16; d++) begin
                    if (in_span((int'(player_x) + d) % 640, m_x[i], 32, 640)) hx = 1;
                    if (in_span((int'(player_y) + d) % 480, m_y[i], 24, 480)) hy = 1;
                end
                if (hx && hy) hit = 1;
            end
            exp_col = hit || (exp_col && !clear_hit);
            for (int i = 0; i < 4; i++) begin
                resp = 0;
                if (move_followers) begin
                    m_y[i] += 2;
                    if (m_y[i] >= 480) begin
                        m_y[i]  -= 480;
                        resp     = 1;
                        m_dir[i] = m_lfsr & 1;
                        m_spd[i] = (m_lfsr >> 1) & 3;
                        if (m_spd[i] == 0) m_spd[i] = 1;
                        m_x[i]   = (((m_lfsr >> 6) & 'h3FF) ^ i) % 640;
                    end
                end
                if (frame_tick && !resp)
                    m_x[i] = m_dir[i] ? (m_x[i] + m_spd[i]) % 640
                                      : (m_x[i] - m_spd[i] + 640) % 640;
            end
            if (m_lfsr & 1) m_lfsr = (m_lfsr >> 1) ^ 'hB400;
            else            m_lfsr = m_lfsr >> 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic pulses(input int n, input bit is_move);
        repeat (n) begin
            if (is_move) move_followers = 1;
            else         frame_tick = 1;
            step();
            move_followers = 0;
            frame_tick     = 0;
            step();
        end
    endtask

    task automatic probe(input string name, input int px, input int py, input int exp);
        pix_x = 10'(px);
        pix_y = 10'(py);
        step();
        check(name, int'(obstacle_px), exp);
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    // Every cycle after the bench is armed, DUT outputs must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("obstacle_px", int'(obstacle_px), int'(exp_obs));
            check("collision", int'(collision), int'(exp_col));
        end
    end

    initial begin
        int rx;
        int lane;
        int sel;
        reset          = 1;
        move_followers = 0;
        frame_tick     = 0;
        clear_hit      = 0;
        pix_x          = 10'd700;
        pix_y          = 10'd500;
        player_x       = 10'd400;
        player_y       = 10'd400;
        step();
        step();
        reset  = 0;
        chk_en = 1;

        // Reset state
        check("rst_obstacle", int'(obstacle_px), 0);
        check("rst_collision", int'(collision), 0);
        probe("pix_5_5", 5, 5, 1);
        probe("lane1_left_edge", 160, 120, 1);
        probe("lane1_left_out", 159, 120, 0);

        // 60 scroll pulses: lane 3 wraps to y=0 on the last one
        pulses(60, 1);
        check("model_lane3_y", m_y[3], 0);
        check("model_lane2_y", m_y[2], 360);
        check("model_lane1_x", m_x[1], 160);
        check("lane3_speed_range", int'(m_spd[3] >= 1 && m_spd[3] <= 3), 1);
        probe("lane3_respawn_in", m_x[3], 0, 1);
        probe("lane3_respawn_end", (m_x[3] + 32) % 640, 23, 0);
        probe("lane1_x_kept_in", 160, 240, 1);
        probe("lane1_x_kept_out", 159, 240, 0);

        // Respawn and frame_tick in the same cycle
        do_reset();
        pulses(59, 1);
        move_followers = 1;
        frame_tick     = 1;
        step();
        move_followers = 0;
        frame_tick     = 0;
        check("model_lane0_x_tick", m_x[0], 639);
        rx = m_x[3];
        probe("resp_tick_first", rx, 0, 1);
        probe("resp_tick_last", (rx + 31) % 640, 23, 1);
        probe("resp_tick_before", (rx + 639) % 640, 0, 0);
        probe("resp_tick_after", (rx + 32) % 640, 0, 0);
        probe("lane0_left_wrap", 639, 120, 1);
        probe("lane0_left_tail", 31, 120, 0);

        // Reset mid-sequence with pulses in flight
        move_followers = 1;
        frame_tick     = 1;
        reset          = 1;
        step();
        reset          = 0;
        move_followers = 0;
        frame_tick     = 0;
        probe("midrst_lane1_a", 160, 120, 1);
        probe("midrst_lane1_b", 191, 120, 1);
        probe("midrst_lane1_c", 192, 120, 0);

        // Horizontal wrap of the footprint, then vertical wrap
        pulses(20, 0);
        check("model_lane0_x620", m_x[0], 620);
        probe("xwrap_630", 630, 5, 1);
        probe("xwrap_11", 11, 5, 1);
        probe("xwrap_12", 12, 5, 0);
        probe("xwrap_619", 619, 5, 0);
        pulses(55, 1);
        check("model_lane3_y470", m_y[3], 470);
        probe("ywrap_13", 505, 13, 1);
        probe("ywrap_14", 505, 14, 0);
        probe("ywrap_470", 505, 470, 1);
        probe("ywrap_469", 505, 469, 0);
        probe("offscreen_x", 700, 5, 0);

        // Sticky collision
        clear_hit = 1;
        step();
        clear_hit = 0;
        check("col_cleared", int'(collision), 0);
        player_x = 10'd188;
        player_y = 10'd234;
        step();
        check("col_rise", int'(collision), 1);
        player_x = 10'd400;
        player_y = 10'd400;
        step();
        check("col_sticky", int'(collision), 1);
        player_x  = 10'd188;
        player_y  = 10'd234;
        clear_hit = 1;
        step();
        check("col_set_wins", int'(collision), 1);
        player_x = 10'd400;
        player_y = 10'd400;
        step();
        clear_hit = 0;
        check("col_clear", int'(collision), 0);

        // Randomised traffic against the model
        do_reset();
        repeat (4000) begin
            reset          = ($urandom_range(0, 399) == 0);
            move_followers = $urandom_range(0, 1);
            frame_tick     = ($urandom_range(0, 3) == 0);
            clear_hit      = ($urandom_range(0, 5) == 0);
            sel  = $urandom_range(0, 9);
            lane = $urandom_range(0, 3);
            if (sel == 0) begin
                pix_x = 10'($urandom_range(0, 1023));
                pix_y = 10'($urandom_range(0, 1023));
            end else if (sel <= 5) begin
                pix_x = 10'((m_x[lane] + $urandom_range(0, 35) - 2 + 640) % 640);
                pix_y = 10'((m_y[lane] + $urandom_range(0, 27) - 2 + 480) % 480);
            end else begin
                pix_x = 10'($urandom_range(0, 639));
                pix_y = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    player_x = 10'((m_x[lane] + $urandom_range(0, 50) - 18 + 640) % 640);
                    player_y = 10'((m_y[lane] + $urandom_range(0, 40) - 18 + 480) % 480);
                end else begin
                    player_x = 10'($urandom_range(0, 639));
                    player_y = 10'($urandom_range(0, 479));
                end
            end
            step();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
